// File: rtl/dcache_write_checker.sv
// Scoreboard that snoops a CPU D-cache write port and checks writes against a
// loadable table of expected (address, data) pairs. Optional per-byte compare
// masks are enabled with the CHECKER_BYTE_MASK_EN macro.
module dcache_write_checker #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int NUM_EXP = 64,
  parameter int ERR_W   = 8,
  parameter int DUR_W   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data,
  input  logic                       wen,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [ADDR_W-1:0]          exp_addr,
`ifdef CHECKER_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0]        exp_mask,
`endif
  input  logic [DATA_W-1:0]          exp_data,
  output logic [ERR_W-1:0]           error_num,
  output logic [DUR_W-1:0]           duration,
  output logic                       finish,
  output logic                       timeout,
  output logic [1:0]                 curstate
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EXP - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [DUR_W-1:0] DUR_MAX  = {DUR_W{1'b1}};

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2,
    S_TOUT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [DUR_W-1:0]   dur_q, dur_d;

  logic [ADDR_W-1:0]  tbl_addr [DEPTH];
  logic [DATA_W-1:0]  tbl_data [DEPTH];
`ifdef CHECKER_BYTE_MASK_EN
  logic [DATA_W/8-1:0] tbl_mask [DEPTH];
`endif

  logic               load_ok;
  logic               hit;
  logic               data_ok;
  logic               last;

  // Loads are only accepted before checking starts so a run sees a stable table.
  assign load_ok = exp_we && (state_q == S_WAIT) && ({1'b0, exp_idx} < DEPTH_L);

  // NOTE: the table has no reset on purpose; it survives rst_n so a rerun needs
  // no reload, and reset-free storage maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
`ifdef CHECKER_BYTE_MASK_EN
      tbl_mask[exp_idx] <= exp_mask;
`endif
    end
  end

  // idx_q stays 0 throughout S_WAIT, so one read port serves both states.
  assign hit  = wen && ((state_q == S_WAIT) || (state_q == S_CHECK))
                    && (addr == tbl_addr[idx_q]);
  assign last = (idx_q == LAST_IDX);

`ifdef CHECKER_BYTE_MASK_EN
  logic [DATA_W-1:0] bit_mask;

  always_comb begin
    bit_mask = '1;
    for (int b = 0; b < DATA_W / 8; b++) begin
      bit_mask[b*8 +: 8] = {8{tbl_mask[idx_q][b]}};
    end
  end

  // An all-zero mask makes the masked difference zero: an automatic pass.
  assign data_ok = (((data ^ tbl_data[idx_q]) & bit_mask) == '0);
`else
  assign data_ok = (data == tbl_data[idx_q]);
`endif

  // NOTE: every variable is given its hold value first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = err_q;
    dur_d   = dur_q;

    if (hit && !data_ok && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end

    unique case (state_q)
      S_WAIT: begin
        if (hit) begin
          idx_d   = idx_q + 1'b1;
          state_d = last ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: begin
        if (dur_q != DUR_MAX) begin
          dur_d = dur_q + 1'b1;
        end
        if (hit) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        // Completion on the same edge as timer expiry takes priority.
        if (state_d == S_CHECK) begin
          if (timer_q == TMR_LAST) begin
            state_d = S_TOUT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_DONE, S_TOUT: ;
      default: state_d = S_WAIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      dur_q   <= dur_d;
    end
  end

  assign error_num = err_q;
  assign duration  = dur_q;
  assign finish    = (state_q == S_DONE);
  assign timeout   = (state_q == S_TOUT);
  assign curstate  = state_q;

endmodule

// File: tb/tb_dcache_write_checker.sv
// Directed bench for dcache_write_checker: instance A (NUM_EXP=4, TIMEOUT=50)
// covers pass/fail/ignore/timeout/reset, instance B (ERR_W=2) covers saturation.
module tb_dcache_write_checker;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen_a, wen_b;
  logic        exp_we_a, exp_we_b;
  logic [2:0]  exp_idx;
  logic [29:0] exp_addr;
  logic [31:0] exp_data;
`ifdef CHECKER_BYTE_MASK_EN
  logic [3:0]  exp_mask;
`endif

  logic [7:0]  err_a;
  logic [15:0] dur_a;
  logic        fin_a, tout_a;
  logic [1:0]  st_a;
  logic [1:0]  err_b;
  logic [15:0] dur_b;
  logic        fin_b, tout_b;
  logic [1:0]  st_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcache_write_checker #(
    .ADDR_W(30), .DATA_W(32), .DEPTH(8), .NUM_EXP(4),
    .ERR_W(8), .DUR_W(16), .TIMEOUT(50)
  ) u_a (
    .clk(clk), .rst_n(rst_a), .addr(addr), .data(data), .wen(wen_a),
    .exp_we(exp_we_a), .exp_idx(exp_idx), .exp_addr(exp_addr),
`ifdef CHECKER_BYTE_MASK_EN
    .exp_mask(exp_mask),
`endif
    .exp_data(exp_data), .error_num(err_a), .duration(dur_a),
    .finish(fin_a), .timeout(tout_a), .curstate(st_a)
  );

  dcache_write_checker #(
    .ADDR_W(30), .DATA_W(32), .DEPTH(8), .NUM_EXP(5),
    .ERR_W(2), .DUR_W(16), .TIMEOUT(1000)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .addr(addr), .data(data), .wen(wen_b),
    .exp_we(exp_we_b), .exp_idx(exp_idx), .exp_addr(exp_addr),
`ifdef CHECKER_BYTE_MASK_EN
    .exp_mask(exp_mask),
`endif
    .exp_data(exp_data), .error_num(err_b), .duration(dur_b),
    .finish(fin_b), .timeout(tout_b), .curstate(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_a(input int i, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    exp_idx = 3'(i); exp_addr = a; exp_data = d; exp_we_a = 1'b1;
    @(negedge clk);
    exp_we_a = 1'b0;
  endtask

  task automatic load_b(input int i, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    exp_idx = 3'(i); exp_addr = a; exp_data = d; exp_we_b = 1'b1;
    @(negedge clk);
    exp_we_b = 1'b0;
  endtask

  // Each call drives one write; consecutive calls give back-to-back writes.
  task automatic wr_a(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; data = d; wen_a = 1'b1;
  endtask

  task automatic wr_b(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; data = d; wen_b = 1'b1;
  endtask

  task automatic idle_a();
    @(negedge clk);
    wen_a = 1'b0;
  endtask

  task automatic pulse_a();
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic correct_run_a();
    wr_a(30'h10, 32'hA);
    wr_a(30'h11, 32'hB);
    wr_a(30'h12, 32'hC);
    wr_a(30'h13, 32'hD);
    idle_a();
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    addr = '0; data = '0; wen_a = 1'b0; wen_b = 1'b0;
    exp_we_a = 1'b0; exp_we_b = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0;
`ifdef CHECKER_BYTE_MASK_EN
    exp_mask = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_dur", 32'(dur_a), 32'd0);
    check("rst_fin", 32'(fin_a), 32'd0);
    check("rst_tout", 32'(tout_a), 32'd0);
    check("rst_state", 32'(st_a), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    load_a(0, 30'h10, 32'hA);
    load_a(1, 30'h11, 32'hB);
    load_a(2, 30'h12, 32'hC);
    load_a(3, 30'h13, 32'hD);

    // All four correct, back to back.
    correct_run_a();
    check("ok_fin", 32'(fin_a), 32'd1);
    check("ok_err", 32'(err_a), 32'd0);
    check("ok_dur", 32'(dur_a), 32'd3);
    check("ok_state", 32'(st_a), 32'd2);
    repeat (3) @(negedge clk);
    check("ok_dur_frozen", 32'(dur_a), 32'd3);
    check("ok_fin_held", 32'(fin_a), 32'd1);

    // Two data mismatches.
    pulse_a();
    wr_a(30'h10, 32'hA);
    wr_a(30'h11, 32'hBB);
    wr_a(30'h12, 32'hC);
    check("bad_err_mid", 32'(err_a), 32'd1);
    wr_a(30'h13, 32'h0);
    idle_a();
    check("bad_err", 32'(err_a), 32'd2);
    check("bad_fin", 32'(fin_a), 32'd1);

    // Unrelated addresses interleaved: ignored, but duration keeps counting.
    pulse_a();
    wr_a(30'h20, 32'h1);
    wr_a(30'h30, 32'h2);
    wr_a(30'h10, 32'hA);
    wr_a(30'h20, 32'h3);
    wr_a(30'h11, 32'hB);
    wr_a(30'h30, 32'h4);
    wr_a(30'h12, 32'hC);
    wr_a(30'h13, 32'hD);
    idle_a();
    check("ign_err", 32'(err_a), 32'd0);
    check("ign_fin", 32'(fin_a), 32'd1);
    check("ign_dur", 32'(dur_a), 32'd5);

    // Timeout: two entries then silence; 50 edges in S_CHECK.
    pulse_a();
    wr_a(30'h10, 32'hA);
    wr_a(30'h11, 32'hB);
    idle_a();
    repeat (48) @(posedge clk);
    @(negedge clk);
    check("tout_pre_state", 32'(st_a), 32'd1);
    check("tout_pre_flag", 32'(tout_a), 32'd0);
    @(negedge clk);
    check("tout_state", 32'(st_a), 32'd3);
    check("tout_flag", 32'(tout_a), 32'd1);
    check("tout_fin", 32'(fin_a), 32'd0);
    check("tout_dur", 32'(dur_a), 32'd50);
    // Load in S_TOUT must be ignored; the rerun below depends on entry 0.
    load_a(0, 30'h55, 32'h99);
    check("tout_dur_frozen", 32'(dur_a), 32'd50);

    // Asynchronous reset mid-S_CHECK, then rerun on the preserved table.
    pulse_a();
    wr_a(30'h10, 32'h1);
    wr_a(30'h11, 32'hB);
    idle_a();
    check("mid_err", 32'(err_a), 32'd1);
    check("mid_state", 32'(st_a), 32'd1);
    #1 rst_a = 1'b0;
    #1;
    check("async_err", 32'(err_a), 32'd0);
    check("async_state", 32'(st_a), 32'd0);
    check("async_dur", 32'(dur_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    correct_run_a();
    check("rerun_fin", 32'(fin_a), 32'd1);
    check("rerun_err", 32'(err_a), 32'd0);
    check("rerun_dur", 32'(dur_a), 32'd3);

    // Error counter saturation on a 2-bit counter.
    for (int i = 0; i < 5; i++) load_b(i, 30'h40 + 30'(i), 32'h100 + 32'(i));
    wr_b(30'h40, 32'h0);
    wr_b(30'h41, 32'h0);
    wr_b(30'h42, 32'h0);
    wr_b(30'h43, 32'h0);
    check("sat_err_mid", 32'(err_b), 32'd3);
    wr_b(30'h44, 32'h0);
    @(negedge clk);
    wen_b = 1'b0;
    check("sat_err", 32'(err_b), 32'd3);
    check("sat_fin", 32'(fin_b), 32'd1);
    check("sat_state", 32'(st_b), 32'd2);

`ifdef CHECKER_BYTE_MASK_EN
    // Masked compare: byte 3 differs but is masked off; entry 1 mask is zero.
    pulse_a();
    exp_mask = 4'b0011;
    load_a(0, 30'h10, 32'h0000000A);
    exp_mask = 4'b0000;
    load_a(1, 30'h11, 32'hB);
    exp_mask = 4'hF;
    wr_a(30'h10, 32'h5500000A);
    wr_a(30'h11, 32'hFFFFFFFF);
    wr_a(30'h12, 32'hC);
    wr_a(30'h13, 32'hD);
    idle_a();
    check("mask_err", 32'(err_a), 32'd0);
    check("mask_fin", 32'(fin_a), 32'd1);
    pulse_a();
    wr_a(30'h10, 32'h0000000B);
    idle_a();
    check("mask_low_err", 32'(err_a), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_write_checker.md
Name: dcache_write_checker

Overview:
- Parametrised self-checking scoreboard for CPU-level benches.
- Snoops the CPU's D-cache write port (word address, write data, write enable) and compares writes against a loadable table of expected (address, data) pairs.
- Reports a saturating error count, elapsed cycle count, completion and timeout.
- Successor to the fixed single-purpose bench checker: configurable address/data width, table depth and timeout; exposes its state for end-of-run diagnostics.

Parameters:
- ADDR_W, 30, width of snooped word address
- DATA_W, 32, width of snooped write data
- DEPTH, 64, expected-table entries (power of 2)
- NUM_EXP, 64, entries actually checked (1..DEPTH)
- ERR_W, 8, error counter width
- DUR_W, 16, duration counter width
- TIMEOUT, 100000, cycles in S_CHECK before timeout flag

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  snooped D-cache word address
- data  in  DATA_W  snooped write data
- wen  in  1  write strobe, sampled on rising clk
- exp_we  in  1  expected-table load strobe
- exp_idx  in  clog2(DEPTH)  table load index
- exp_addr  in  ADDR_W  expected address for entry
- exp_data  in  DATA_W  expected data for entry
- error_num  out  ERR_W  mismatches so far
- duration  out  DUR_W  cycles from first matched write to finish
- finish  out  1  all NUM_EXP entries checked
- timeout  out  1  TIMEOUT cycles elapsed in S_CHECK without finishing
- curstate  out  2  FSM state: 0 S_WAIT, 1 S_CHECK, 2 S_DONE, 3 S_TOUT

Behaviour:
- Reset (rst_n low, async) clears all of the following; the table contents are not reset:
  - outputs: error_num, duration, finish, timeout, curstate = 0
  - internal: idx = 0, timer = 0
- Table load:
  - exp_we writes entry exp_idx on the rising edge; accepted in S_WAIT only, ignored elsewhere.
  - exp_idx >= DEPTH is ignored.
- S_WAIT:
  - Waits for wen with addr == table[0].addr.
  - On that write: compare data, idx <= 1, and go to S_CHECK, or to S_DONE if NUM_EXP == 1.
  - Other writes are ignored.
- S_CHECK:
  - Each wen with addr == table[idx].addr compares data and increments idx.
  - Writes to any other address are ignored; no error is counted.
  - When the compared entry is idx == NUM_EXP-1: go to S_DONE.
  - If timer reaches TIMEOUT-1: go to S_TOUT.
- Comparison: a mismatch increments error_num, saturating at 2^ERR_W-1. The result is registered; error_num updates one cycle after the sampled write.
- duration:
  - Increments every cycle in S_CHECK, starting from the cycle after the first match.
  - Saturates at 2^DUR_W-1.
  - Frozen in S_DONE and S_TOUT.
- finish:
  - Rises on the cycle S_DONE is entered, registered together with the final error_num update.
  - Stays high until reset.
- timeout: high in S_TOUT; finish stays low. S_DONE and S_TOUT are terminal until rst_n.
- Simultaneous final match and timer expiry: S_DONE wins.
- Reset mid-run:
  - Counters, flags and FSM return to zero immediately.
  - The table is preserved, so a rerun needs no reload.
- One compare per cycle; back-to-back wen every cycle must be handled.

Optional Feature:
- Macro CHECKER_BYTE_MASK_EN.
- When defined:
  - Adds input port exp_mask, width DATA_W/8, stored per entry on load.
  - Comparison covers only the bytes whose mask bit is 1.
  - An all-zero mask counts as an automatic pass, but idx still advances.
- When undefined: no port, no mask storage, full-word compare.

Test Plan:
- NUM_EXP=4, table {(0x10,0xA),(0x11,0xB),(0x12,0xC),(0x13,0xD)}, CPU writes all four correctly, one per cycle -> finish high 1 cycle after 4th write, error_num=0, duration=3, curstate=2.
- Same table, 2nd write data 0xBB, 4th write data 0x0 -> error_num=2, finish high.
- Writes to 0x20 and 0x30 interleaved before and between expected writes -> ignored, error_num=0, duration counts the extra cycles.
- TIMEOUT=50, only first two entries written -> timeout high at cycle 50 of S_CHECK, finish=0, curstate=3, duration=50.
- ERR_W=2, NUM_EXP=5, all five mismatching -> error_num saturates at 3.
- rst_n pulsed low mid-S_CHECK, then rerun correct sequence -> outputs zero during reset; finish with error_num=0 using the preserved table.
- With CHECKER_BYTE_MASK_EN, mask 4'b0011 on entry 0, data differing only in byte 3 -> error_num=0.
